// File: rtl/vdp_io_pkg.sv
// Shared types and constants for the VDP CPU-port initiator.
// Optional VDP_BOOT_INIT_EN adds the boot-time register table.
package vdp_io_pkg;

    typedef struct packed {
        logic       wr;
        logic [1:0] port;
        logic [7:0] data;
    } vdp_cmd_t;

    localparam logic [1:0] VDP_PORT_DATA = 2'd0;
    localparam logic [1:0] VDP_PORT_CTRL = 2'd1;
    localparam logic [1:0] VDP_PORT_PAL  = 2'd2;
    localparam logic [1:0] VDP_PORT_IND  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } vdp_state_e;

`ifdef VDP_BOOT_INIT_EN
    localparam int BOOT_LEN = 16;

    // Pairs of (value, 0x80 | reg) written to the control port.
    localparam vdp_cmd_t BOOT_TABLE [BOOT_LEN] = '{
        {1'b1, VDP_PORT_CTRL, 8'h00}, {1'b1, VDP_PORT_CTRL, 8'h80},
        {1'b1, VDP_PORT_CTRL, 8'h50}, {1'b1, VDP_PORT_CTRL, 8'h81},
        {1'b1, VDP_PORT_CTRL, 8'h00}, {1'b1, VDP_PORT_CTRL, 8'h82},
        {1'b1, VDP_PORT_CTRL, 8'h00}, {1'b1, VDP_PORT_CTRL, 8'h83},
        {1'b1, VDP_PORT_CTRL, 8'h01}, {1'b1, VDP_PORT_CTRL, 8'h84},
        {1'b1, VDP_PORT_CTRL, 8'h00}, {1'b1, VDP_PORT_CTRL, 8'h85},
        {1'b1, VDP_PORT_CTRL, 8'h00}, {1'b1, VDP_PORT_CTRL, 8'h86},
        {1'b1, VDP_PORT_CTRL, 8'hF4}, {1'b1, VDP_PORT_CTRL, 8'h87}
    };
`endif

endpackage

// File: rtl/vdp_cmd_fifo.sv
// Synchronous command FIFO for the VDP initiator.
// Pointers wrap naturally because the depth is a power of two.
module vdp_cmd_fifo
    import vdp_io_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  vdp_cmd_t      wdata,
    input  logic          pop,
    output vdp_cmd_t      rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    vdp_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vdp_io_master.sv
// On-chip initiator issuing queued accesses to the VDP CPU port.
// Define VDP_BOOT_INIT_EN to replay the boot register table after reset.
module vdp_io_master
    import vdp_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_GAP    = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [1:0] cmd_port,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    output logic       vdp_req,
    output logic       vdp_wrt,
    output logic [1:0] vdp_adr,
    output logic [7:0] vdp_dbo,
    input  logic       vdp_ack,
    input  logic [7:0] vdp_dbi
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 1);

    vdp_state_e    state_q, state_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    vdp_cmd_t      fifo_rdata;
    vdp_cmd_t      head;
    vdp_cmd_t      boot_cmd;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic [AW:0]   count_d;
    logic          push;
    logic          fifo_pop;
    logic          boot_sel;
    logic          launch;
    logic          done_ok;
    logic          done_to;
    logic          cur_boot_q;

    assign cmd_ready = ~fifo_full & ~boot_sel;
    assign push      = cmd_valid & cmd_ready;
    assign head      = boot_sel ? boot_cmd : fifo_rdata;
    assign count_d   = fifo_count
                     + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, fifo_pop};

    vdp_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({cmd_wr, cmd_port, cmd_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef VDP_BOOT_INIT_EN
    logic [4:0] boot_idx_q;

    assign boot_sel = ~boot_idx_q[4];
    assign boot_cmd = BOOT_TABLE[boot_idx_q[3:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            boot_idx_q <= '0;
        end else if (launch && boot_sel) begin
            boot_idx_q <= boot_idx_q + 5'd1;
        end
    end
`else
    assign boot_sel = 1'b0;
    assign boot_cmd = '0;
`endif

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        fifo_pop  = 1'b0;
        launch    = 1'b0;
        done_ok   = 1'b0;
        done_to   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (boot_sel || !fifo_empty) begin
                    launch   = 1'b1;
                    fifo_pop = ~boot_sel;
                    to_cnt_d = '0;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (vdp_ack) begin
                    done_ok   = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else if (to_cnt_q == TO_LAST) begin
                    done_to   = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            vdp_req    <= 1'b0;
            vdp_wrt    <= 1'b0;
            vdp_adr    <= '0;
            vdp_dbo    <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            cur_boot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            busy      <= (state_d != ST_IDLE) || (count_d != '0) || boot_sel;
            rsp_valid <= (done_ok | done_to) & ~cur_boot_q;
            if (launch) begin
                vdp_req    <= 1'b1;
                vdp_wrt    <= head.wr;
                vdp_adr    <= head.port;
                vdp_dbo    <= head.data;
                cur_boot_q <= boot_sel;
            end
            if (done_ok || done_to) begin
                vdp_req <= 1'b0;
            end
            if ((done_ok || done_to) && !cur_boot_q) begin
                rsp_err  <= done_to;
                rsp_data <= done_to ? 8'hFF : (vdp_wrt ? 8'h00 : vdp_dbi);
            end
        end
    end

endmodule

// File: tb/tb_vdp_io_master.sv
// Directed self-checking bench for vdp_io_master.
// Build with VDP_BOOT_INIT_EN to also cover the boot table replay.
module tb_vdp_io_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_wr = 1'b0;
    logic [1:0] cmd_port = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       vdp_req;
    logic       vdp_wrt;
    logic [1:0] vdp_adr;
    logic [7:0] vdp_dbo;
    logic       vdp_ack = 1'b0;
    logic [7:0] vdp_dbi = '0;

    int checks = 0;
    int errors = 0;

`ifdef VDP_BOOT_INIT_EN
    localparam logic EXP_READY_RST = 1'b0;
`else
    localparam logic EXP_READY_RST = 1'b1;
`endif

    always #5 clk = ~clk;

    vdp_io_master #(
        .FIFO_DEPTH (4),
        .MIN_GAP    (8),
        .TIMEOUT    (255)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_port  (cmd_port),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .vdp_req   (vdp_req),
        .vdp_wrt   (vdp_wrt),
        .vdp_adr   (vdp_adr),
        .vdp_dbo   (vdp_dbo),
        .vdp_ack   (vdp_ack),
        .vdp_dbi   (vdp_dbi)
    );

    // VDP model: ack after ack_delay req cycles, data = dbi_val + port.
    bit         ack_en = 1'b1;
    int         ack_delay = 0;
    logic [7:0] dbi_val = '0;
    int         force_cnt = 0;
    int         force_done = 0;
    int         req_cyc = 0;
    bit         acked = 1'b0;

    always @(negedge clk) begin
        vdp_ack = 1'b0;
        if (force_cnt != force_done) begin
            vdp_ack = 1'b1;
            force_done = force_cnt;
        end else if (vdp_req && !acked) begin
            if (ack_en && req_cyc >= ack_delay) begin
                vdp_ack = 1'b1;
                vdp_dbi = dbi_val + {6'b0, vdp_adr};
                acked = 1'b1;
            end
            req_cyc++;
        end else if (!vdp_req) begin
            req_cyc = 0;
            acked = 1'b0;
        end
    end

    logic [8:0] rsp_q [$];
    int         rise_cnt = 0;
    int         low_run = 0;
    int         high_run = 0;
    int         last_low = 0;
    int         last_high = 0;
    logic [7:0] rise_dbo = '0;
    logic [1:0] rise_adr = '0;
    logic       rise_wrt = 1'b0;
    logic       prev_req = 1'b0;

    always @(negedge clk) begin
        if (rsp_valid) rsp_q.push_back({rsp_err, rsp_data});
        if (vdp_req && !prev_req) begin
            rise_cnt++;
            last_low = low_run;
            rise_dbo = vdp_dbo;
            rise_adr = vdp_adr;
            rise_wrt = vdp_wrt;
        end
        if (!vdp_req && prev_req) last_high = high_run;
        if (vdp_req) begin
            high_run++;
            low_run = 0;
        end else begin
            low_run++;
            high_run = 0;
        end
        prev_req = vdp_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic wr, input logic [1:0] port,
                            input logic [7:0] data, output logic acc);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_port  = port;
        cmd_data  = data;
        acc       = cmd_ready;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || !cmd_ready) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n;
        n = 0;
        while (!rsp_valid && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_count(input string tag, input int target,
                              input int budget);
        int n;
        n = 0;
        while (rsp_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({tag, "_cnt_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic boot_wait();
`ifdef VDP_BOOT_INIT_EN
        int r0;
        r0 = rise_cnt;
        wait_idle("boot", 2000);
        chk("boot_writes", rise_cnt - r0, 16);
        chk("boot_no_rsp", rsp_q.size(), 0);
        chk("boot_ready", cmd_ready, 1);
`endif
    endtask

    initial begin
        logic acc;
        int   base;
        int   r0;
        int   n;
        bit   got;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_req", vdp_req, 0);
        chk("rst_wrt", vdp_wrt, 0);
        chk("rst_adr", vdp_adr, 0);
        chk("rst_dbo", vdp_dbo, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, EXP_READY_RST);
        boot_wait();

        // Two control-port writes back to back.
        base = rsp_q.size();
        r0 = rise_cnt;
        ack_delay = 2;
        push_cmd(1'b1, 2'd1, 8'h00, acc);
        chk("w1_acc", acc, 1);
        chk("w1_req_cyc1", vdp_req, 0);
        chk("w1_busy", busy, 1);
        push_cmd(1'b1, 2'd1, 8'h87, acc);
        chk("w1_req_cyc2", vdp_req, 1);
        chk("w1_adr", vdp_adr, 1);
        chk("w1_wrt", vdp_wrt, 1);
        chk("w1_dbo", vdp_dbo, 8'h00);
        wait_count("w1", base + 2, 100);
        chk("w1_rises", rise_cnt - r0, 2);
        chk("w1_gap_low", last_low, 9);
        chk("w1_2nd_dbo", rise_dbo, 8'h87);
        chk("w1_2nd_adr", rise_adr, 1);
        chk("w1_2nd_wrt", rise_wrt, 1);
        chk("w1_rsp0", rsp_q[base], 9'h000);
        chk("w1_rsp1", rsp_q[base + 1], 9'h000);
        wait_idle("w1", 100);

        // Read with a 3-cycle ack delay.
        ack_delay = 3;
        dbi_val = 8'hA5;
        push_cmd(1'b0, 2'd0, 8'h5A, acc);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (vdp_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk("rd_ack_seen", got, 1);
        tick();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_data", rsp_data, 8'hA5);
        chk("rd_rsp_err", rsp_err, 0);
        chk("rd_req_drop", vdp_req, 0);
        chk("rd_req_len", last_high, 4);

        // Fill the FIFO during the gap while acks are stalled.
        ack_en = 1'b0;
        dbi_val = 8'h30;
        base = rsp_q.size();
        push_cmd(1'b0, 2'd0, 8'h00, acc);
        push_cmd(1'b0, 2'd1, 8'h00, acc);
        push_cmd(1'b0, 2'd2, 8'h00, acc);
        push_cmd(1'b0, 2'd3, 8'h00, acc);
        chk("ff_acc4", acc, 1);
        chk("ff_ready_low", cmd_ready, 0);
        push_cmd(1'b0, 2'd1, 8'h00, acc);
        chk("ff_acc5", acc, 0);
        repeat (20) tick();
        chk("ff_stall_req", vdp_req, 1);
        chk("ff_stall_none", rsp_q.size() - base, 0);
        ack_en = 1'b1;
        wait_count("ff", base + 4, 200);
        repeat (30) tick();
        chk("ff_count", rsp_q.size() - base, 4);
        chk("ff_rsp0", rsp_q[base], 9'h030);
        chk("ff_rsp1", rsp_q[base + 1], 9'h031);
        chk("ff_rsp2", rsp_q[base + 2], 9'h032);
        chk("ff_rsp3", rsp_q[base + 3], 9'h033);
        wait_idle("ff", 100);

        // Never ack: timeout after 255 req cycles.
        ack_en = 1'b0;
        ack_delay = 0;
        push_cmd(1'b1, 2'd2, 8'h11, acc);
        wait_rsp("to", 400);
        chk("to_err", rsp_err, 1);
        chk("to_data", rsp_data, 8'hFF);
        chk("to_req_drop", vdp_req, 0);
        chk("to_req_len", last_high, 255);
        ack_en = 1'b1;
        dbi_val = 8'h40;
        push_cmd(1'b0, 2'd3, 8'h00, acc);
        wait_rsp("to_next", 100);
        chk("to_next_err", rsp_err, 0);
        chk("to_next_data", rsp_data, 8'h43);
        wait_idle("to", 100);

        // Ack in the very cycle the timeout expires.
        ack_delay = 254;
        dbi_val = 8'h10;
        push_cmd(1'b0, 2'd1, 8'h00, acc);
        wait_rsp("edge", 400);
        chk("edge_err", rsp_err, 0);
        chk("edge_data", rsp_data, 8'h11);
        chk("edge_req_len", last_high, 255);
        ack_delay = 0;
        wait_idle("edge", 100);

        // Stray ack while idle is ignored.
        base = rsp_q.size();
        force_cnt++;
        repeat (4) tick();
        chk("stray_rsp", rsp_q.size() - base, 0);
        chk("stray_busy", busy, 0);
        chk("stray_req", vdp_req, 0);

        // Reset in the middle of a request.
        ack_en = 1'b0;
        push_cmd(1'b1, 2'd0, 8'h22, acc);
        repeat (5) tick();
        chk("mr_req_before", vdp_req, 1);
        base = rsp_q.size();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_req", vdp_req, 0);
        chk("mr_busy", busy, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        ack_en = 1'b1;
        boot_wait();
        n = 0;
        repeat (20) begin
            tick();
            n++;
        end
        chk("mr_no_rsp", rsp_q.size() - base, 0);
        chk("mr_ready", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vdp_io_master.md
# vdp_io_master

On-chip initiator for the VDP CPU-port protocol: issues queued read/write accesses to the four VDP I/O ports over the `req`/`wrt`/`adr`/`dbo`/`ack`/`dbi` handshake and returns the read data. It sits on the `clk_w` domain beside `cpu_io` and lets internal logic program the VDP without an external Z80, for example to load boot-time registers or to run self-test sequences. A small command FIFO buffers requests, enforces the inter-access gap and applies an acknowledge timeout.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `MIN_GAP`, 8: idle `clk` cycles forced between the end of one access and the next `req`.
- `TIMEOUT`, 255: cycles to wait for `ack` before aborting; must be at least 1.
- `clk` in 1: pixel/VDP clock (`clk_w`).
- `reset` in 1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_wr` in 1: 1 = write, 0 = read.
- `cmd_port` in 2: VDP port 0..3.
- `cmd_data` in 8: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse when an access completes.
- `rsp_data` out 8: read data; 0 for writes.
- `rsp_err` out 1: access timed out; qualified by `rsp_valid`.
- `busy` out 1: FIFO non-empty or an access is in flight.
- `vdp_req` out 1: access request to the VDP.
- `vdp_wrt` out 1: write strobe qualifier.
- `vdp_adr` out 2: port select.
- `vdp_dbo` out 8: data to the VDP.
- `vdp_ack` in 1: access accepted. A single-cycle pulse.
- `vdp_dbi` in 8: VDP read data, valid in the cycle `vdp_ack` is high.

## Operation
- FIFO push on `cmd_valid & cmd_ready`. When the FIFO is full, `cmd_ready` = 0 and commands offered in that state are not stored.
- FSM states: IDLE, REQ, GAP.
  - IDLE: if the FIFO is non-empty, pop the head, register `vdp_wrt`/`vdp_adr`/`vdp_dbo` and set `vdp_req` = 1. Go to REQ.
  - REQ: hold all vdp outputs stable and count cycles.
    - On `vdp_ack`: drop `vdp_req` the next cycle, pulse `rsp_valid` with `rsp_data` = `vdp_dbi` (reads) or 0 (writes) and `rsp_err` = 0. Go to GAP.
    - If the counter reaches TIMEOUT with no ack: drop `vdp_req`, pulse `rsp_valid` with `rsp_err` = 1 and `rsp_data` = 0xFF. Go to GAP.
  - GAP: count MIN_GAP cycles, then go to IDLE.
- Simultaneous push and pop in the same cycle is legal; the occupancy count is unchanged.
- A push while the FIFO is full and a pop occurs in the same cycle is still refused, because `cmd_ready` was 0.
- Responses are returned in command order, exactly one per command.
- Read-pointer and write-pointer arithmetic wraps modulo FIFO_DEPTH. The occupancy counter is log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values: `vdp_req` = 0, `vdp_wrt` = 0, `vdp_adr` = 0, `vdp_dbo` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0, `busy` = 0, `cmd_ready` = 1. The FIFO is emptied and the FSM enters IDLE.
- Reset during REQ: `vdp_req` is low in the cycle after `reset` is sampled, and no response is produced.
- Latency with an empty FIFO: a push at cycle 0 gives `vdp_req` high at cycle 2.
- An ack at cycle n gives `rsp_valid` at cycle n+1.
- The next `vdp_req` rises no earlier than n+2+MIN_GAP.
- An ack arriving in the same cycle the timeout expires counts as success.
- A `vdp_ack` seen in IDLE or GAP is ignored.
- `busy` is registered and stays high through GAP.

## Configuration
- `VDP_BOOT_INIT_EN` defined:
  - After reset, the block first plays a fixed 16-entry table of port-1 register writes (value, then 0x80|reg). The table lives in the shared package.
  - These are injected ahead of FIFO commands. `cmd_ready` = 0 until the table is finished.
  - Boot accesses produce no `rsp_valid`.
- `VDP_BOOT_INIT_EN` undefined: the table and its sequencer are absent, and `cmd_ready` = 1 straight out of reset.

## Structure
- Shared package `vdp_io_pkg`:
  - `vdp_cmd_t` packed struct {wr, port[1:0], data[7:0]}.
  - Port constants `VDP_PORT_DATA`=0, `VDP_PORT_CTRL`=1, `VDP_PORT_PAL`=2, `VDP_PORT_IND`=3.
  - The boot table constant.
- One sub-module, `vdp_cmd_fifo`: a synchronous FIFO of `vdp_cmd_t` with full/empty flags. The FSM lives in the top of this block.

## Test plan
- Write port 1 data 0x00, then port 1 data 0x87: two `vdp_req` phases with `vdp_adr` = 1 and `vdp_wrt` = 1. The second `req` rises at least MIN_GAP cycles after the first ack. Two responses, both with `rsp_err` = 0.
- Read port 0 while the bench acks with `vdp_dbi` = 0xA5 after 3 cycles: `rsp_valid` one cycle after the ack, with `rsp_data` = 0xA5.
- Push 5 commands with FIFO_DEPTH = 4 while acks are stalled: `cmd_ready` goes low after the 4th push and the 5th command is not accepted. Releasing acks yields exactly 4 responses, in order.
- Never assert `vdp_ack`: after 255 cycles `vdp_req` falls and `rsp_err` = 1 with `rsp_data` = 0xFF. The following command proceeds normally.
- Assert `reset` mid-REQ: `vdp_req` is 0 the next cycle, `busy` = 0, and no `rsp_valid` is produced.
- With `VDP_BOOT_INIT_EN` defined: 16 port-1 writes run after reset with no `rsp_valid`, then `cmd_ready` rises.
